por_reset_sequencer: RTL and testbench
======================================

POR_RESET_SEQUENCER -- requirements
Module: por_reset_sequencer

Interface
REQ-001 SHALL provide parameter N_DOMAINS, default 3, number of sequenced core reset domains (1..8).
REQ-002 SHALL provide parameter SYNC_STAGES, default 2, synchronizer depth for POR_N_I (2..4).
REQ-003 SHALL provide parameter FILTER_CYCLES, default 16, number of consecutive synchronized-high cycles required before release (1..255).
REQ-004 SHALL provide parameter STAGE_GAP, default 8, cycles between successive domain releases and the software-reset hold time (1..255).
REQ-005 SHALL have CLK_I  input  1  single clock; all state updates on its rising edge.
REQ-006 SHALL have RST_I  input  1  reset, synchronous and active-high.
REQ-007 SHALL have POR_N_I  input  1  asynchronous active-low power-on-reset from the POR cell output (POR_N_CORE_O).
REQ-008 SHALL have SW_RST_REQ_I  input  1  level software-reset request, held high until acknowledged.
REQ-009 SHALL have SW_RST_ACK_O  output  1  one-cycle acknowledge pulse.
REQ-010 SHALL have RST_N_O  output  N_DOMAINS  registered active-low domain resets; bit 0 released first.
REQ-011 SHALL have READY_O  output  1  high when all domains are released.

Function
REQ-012 SHALL pass POR_N_I through a SYNC_STAGES flop chain to form por_sync; no other logic may sample POR_N_I.
REQ-013 SHALL implement states HOLD, FILTER, RELEASE, RUN, SW_HOLD.
REQ-014 HOLD: RST_N_O all 0, READY_O 0, counters cleared; go to FILTER on first cycle por_sync=1.
REQ-015 FILTER: 8-bit counter increments each por_sync=1 cycle; any por_sync=0 returns to HOLD with counter cleared; on reaching FILTER_CYCLES go to RELEASE and set RST_N_O[0]=1.
REQ-016 If t0 is the first edge with por_sync=1, RST_N_O[k] SHALL rise at edge t0+FILTER_CYCLES+k*STAGE_GAP, never earlier; released bits stay 1 until re-entry to HOLD or SW_HOLD.
REQ-017 READY_O SHALL rise on the same edge as RST_N_O[N_DOMAINS-1]; state becomes RUN.
REQ-018 In any non-HOLD state, por_sync=0 SHALL, on the next edge, drive RST_N_O to all 0, READY_O to 0 and state to HOLD; this takes priority over every other event.
REQ-019 In RUN with SW_RST_REQ_I=1: next edge RST_N_O all 0, READY_O 0, state SW_HOLD.
REQ-020 SW_HOLD: hold STAGE_GAP cycles, then pulse SW_RST_ACK_O for exactly one cycle and enter RELEASE directly (no FILTER), releasing bit 0 on that edge and sequencing as REQ-016.
REQ-021 SW_RST_REQ_I outside RUN SHALL be ignored (no ack) until RUN is reached; a request still high after ack SHALL not retrigger until it has been seen low for at least one cycle.
REQ-022 With N_DOMAINS=1, RST_N_O[0] and READY_O SHALL rise on the same edge.
REQ-023 Counters SHALL never wrap; saturate at terminal count.

Reset
REQ-024 On RST_I=1 at a clock edge: state HOLD, synchronizer flops 0, counters 0, RST_N_O all 0, READY_O 0, SW_RST_ACK_O 0, rearm flag cleared; RST_I overrides POR_N_I and SW_RST_REQ_I.
REQ-025 RST_I asserted mid-RELEASE or mid-SW_HOLD SHALL abort the sequence with the above values on the next edge.

Structure
REQ-026 Package por_seq_pkg SHALL hold the state enum and default parameter constants.
REQ-027 The synchronizer SHALL be a separate sub-module por_sync_cell (parameter SYNC_STAGES, sync reset to 0).

Verification
REQ-028 Defaults; POR_N_I high at edge e -> RST_N_O[0] rises e+18, [1] e+26, [2] e+34, READY_O e+34.
REQ-029 POR_N_I glitches low 1 cycle at 10th FILTER cycle -> counter restarts; release delayed by 10+sync cycles; no output toggles.
REQ-030 In RUN, POR_N_I drops -> RST_N_O=000 and READY_O=0 exactly SYNC_STAGES+1 edges later.
REQ-031 In RUN, SW_RST_REQ_I held high -> RST_N_O=000 next edge, ACK pulse 8 cycles later, domains re-released at ack+0/+8/+16; no second ack while request stays high.
REQ-032 RST_I pulsed during RELEASE after domain 1 release -> all outputs 0 next edge; full FILTER sequence repeats.
REQ-033 SW_RST_REQ_I and POR_N_I drop on same edge in RUN -> HOLD path taken, no ACK.

Source files
------------

// File: rtl/por_seq_pkg.sv
// Shared state encoding, default parameters and counter helper for the
// power-on reset sequencer.
package por_seq_pkg;

  typedef enum logic [2:0] {
    ST_HOLD,
    ST_FILTER,
    ST_RELEASE,
    ST_RUN,
    ST_SW_HOLD
  } state_t;

  localparam int DEF_N_DOMAINS     = 3;
  localparam int DEF_SYNC_STAGES   = 2;
  localparam int DEF_FILTER_CYCLES = 16;
  localparam int DEF_STAGE_GAP     = 8;

  // Saturating increment: counters stick at terminal count instead of wrapping.
  function automatic logic [7:0] sat_inc(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

endpackage

// File: rtl/por_sync_cell.sv
// Flop chain bringing the asynchronous POR level into the clock domain;
// clears to 0 so a reset always reads as "power not good".
module por_sync_cell #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic dout
);

  logic [SYNC_STAGES-1:0] chain;

  always_ff @(posedge clk) begin
    if (rst) chain <= '0;
    else     chain <= {chain[SYNC_STAGES-2:0], din};
  end

  assign dout = chain[SYNC_STAGES-1];

endmodule

// File: rtl/por_reset_sequencer.sv
// Filters the synchronized POR level, then releases the core reset domains
// one by one; also services a software-requested reset cycle from RUN.
module por_reset_sequencer
  import por_seq_pkg::*;
#(
  parameter int N_DOMAINS     = DEF_N_DOMAINS,
  parameter int SYNC_STAGES   = DEF_SYNC_STAGES,
  parameter int FILTER_CYCLES = DEF_FILTER_CYCLES,
  parameter int STAGE_GAP     = DEF_STAGE_GAP
) (
  input  logic                 CLK_I,
  input  logic                 RST_I,
  input  logic                 POR_N_I,
  input  logic                 SW_RST_REQ_I,
  output logic                 SW_RST_ACK_O,
  output logic [N_DOMAINS-1:0] RST_N_O,
  output logic                 READY_O
);

  localparam logic [7:0]           FILT_TC = 8'(FILTER_CYCLES);
  localparam logic [7:0]           GAP_TC  = 8'(STAGE_GAP - 1);
  localparam logic [N_DOMAINS-1:0] FIRST   = N_DOMAINS'(1);

  logic                 por_sync;
  state_t               state;
  logic [7:0]           filt_cnt;
  logic [7:0]           gap_cnt;
  logic [N_DOMAINS-1:0] rst_n;
  logic [N_DOMAINS-1:0] rst_n_next;
  logic                 ready;
  logic                 ack;
  logic                 sw_block;

  por_sync_cell #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_sync (
    .clk (CLK_I),
    .rst (RST_I),
    .din (POR_N_I),
    .dout(por_sync)
  );

  // Released bits fill upward from bit 0, so the next release is a shift-in of 1.
  assign rst_n_next = (rst_n << 1) | FIRST;

  always_ff @(posedge CLK_I) begin
    if (RST_I) begin
      state    <= ST_HOLD;
      filt_cnt <= '0;
      gap_cnt  <= '0;
      rst_n    <= '0;
      ready    <= 1'b0;
      ack      <= 1'b0;
      sw_block <= 1'b0;
    end else begin
      ack <= 1'b0;
      if (!SW_RST_REQ_I) sw_block <= 1'b0;

      // Loss of power-good outranks every other event outside HOLD.
      if (state != ST_HOLD && !por_sync) begin
        state    <= ST_HOLD;
        filt_cnt <= '0;
        gap_cnt  <= '0;
        rst_n    <= '0;
        ready    <= 1'b0;
      end else begin
        case (state)
          ST_HOLD: begin
            rst_n    <= '0;
            ready    <= 1'b0;
            gap_cnt  <= '0;
            filt_cnt <= '0;
            if (por_sync) begin
              state    <= ST_FILTER;
              filt_cnt <= 8'd1;
            end
          end
          ST_FILTER: begin
            if (filt_cnt >= FILT_TC) begin
              rst_n   <= FIRST;
              gap_cnt <= '0;
              ready   <= FIRST[N_DOMAINS-1];
              state   <= FIRST[N_DOMAINS-1] ? ST_RUN : ST_RELEASE;
            end else begin
              filt_cnt <= sat_inc(filt_cnt);
            end
          end
          ST_RELEASE: begin
            if (gap_cnt >= GAP_TC) begin
              rst_n   <= rst_n_next;
              gap_cnt <= '0;
              if (rst_n_next[N_DOMAINS-1]) begin
                ready <= 1'b1;
                state <= ST_RUN;
              end
            end else begin
              gap_cnt <= sat_inc(gap_cnt);
            end
          end
          ST_RUN: begin
            if (SW_RST_REQ_I && !sw_block) begin
              state    <= ST_SW_HOLD;
              rst_n    <= '0;
              ready    <= 1'b0;
              gap_cnt  <= '0;
              filt_cnt <= '0;
            end
          end
          ST_SW_HOLD: begin
            if (gap_cnt >= GAP_TC) begin
              // Filtering is skipped: power was never lost.
              ack      <= 1'b1;
              sw_block <= 1'b1;
              rst_n    <= FIRST;
              gap_cnt  <= '0;
              ready    <= FIRST[N_DOMAINS-1];
              state    <= FIRST[N_DOMAINS-1] ? ST_RUN : ST_RELEASE;
            end else begin
              gap_cnt <= sat_inc(gap_cnt);
            end
          end
          default: begin
            state <= ST_HOLD;
            rst_n <= '0;
            ready <= 1'b0;
          end
        endcase
      end
    end
  end

  assign RST_N_O      = rst_n;
  assign READY_O      = ready;
  assign SW_RST_ACK_O = ack;

endmodule

// File: tb/tb_por_reset_sequencer.sv
// Directed bench: default-parameter sequencer plus a single-domain,
// minimum-timing instance sharing the same stimulus.
module tb_por_reset_sequencer;

  logic       clk;
  logic       rst;
  logic       por_n;
  logic       sw_req;
  logic       ack;
  logic [2:0] rst_n;
  logic       ready;
  logic       ack1;
  logic [0:0] rst_n1;
  logic       ready1;

  int checks = 0;
  int errors = 0;
  int ack_count = 0;

  por_reset_sequencer dut (
    .CLK_I       (clk),
    .RST_I       (rst),
    .POR_N_I     (por_n),
    .SW_RST_REQ_I(sw_req),
    .SW_RST_ACK_O(ack),
    .RST_N_O     (rst_n),
    .READY_O     (ready)
  );

  por_reset_sequencer #(
    .N_DOMAINS    (1),
    .SYNC_STAGES  (2),
    .FILTER_CYCLES(1),
    .STAGE_GAP    (1)
  ) dut1 (
    .CLK_I       (clk),
    .RST_I       (rst),
    .POR_N_I     (por_n),
    .SW_RST_REQ_I(sw_req),
    .SW_RST_ACK_O(ack1),
    .RST_N_O     (rst_n1),
    .READY_O     (ready1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) if (ack) ack_count++;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Runs n edges; tick 'first' is when domain 0 must release, later domains
  // follow every 8 edges. first1 > 0 also checks the single-domain instance.
  task automatic check_seq(input string tag, input int first, input int n,
                           input bit with_ack, input int first1);
    logic [2:0] exp;
    for (int i = 1; i <= n; i++) begin
      tick();
      for (int k = 0; k < 3; k++) exp[k] = (i >= first + k * 8);
      chk({tag, "_rst_n"}, 32'(rst_n), 32'(exp));
      chk({tag, "_ready"}, 32'(ready), 32'(i >= first + 16));
      chk({tag, "_ack"}, 32'(ack), 32'(with_ack && i == first));
      if (first1 > 0) begin
        chk({tag, "_rst_n1"}, 32'(rst_n1), 32'(i >= first1));
        chk({tag, "_ready1"}, 32'(ready1), 32'(i >= first1));
      end
    end
  endtask

  initial begin
    rst = 1'b1; por_n = 1'b0; sw_req = 1'b0;
    repeat (3) tick();
    chk("reset_rst_n", 32'(rst_n), 32'h0);
    chk("reset_ready", 32'(ready), 32'h0);
    chk("reset_ack", 32'(ack), 32'h0);

    // RST_I must dominate a good POR level.
    por_n = 1'b1;
    repeat (25) tick();
    chk("rst_override_rst_n", 32'(rst_n), 32'h0);
    chk("rst_override_rst_n1", 32'(rst_n1), 32'h0);

    // Power-up from reset release: domains at +18/+26/+34.
    rst = 1'b0;
    check_seq("powerup", 19, 36, 1'b0, 4);

    // Software reset, request held high: single ack then re-release.
    sw_req = 1'b1;
    check_seq("swrst", 9, 40, 1'b1, 0);
    chk("swrst_ack_count", 32'(ack_count), 32'd1);

    // Request must be seen low before it can fire again.
    sw_req = 1'b0;
    tick();
    chk("rearm_idle_rst_n", 32'(rst_n), 32'h7);
    sw_req = 1'b1;
    check_seq("rearm", 9, 30, 1'b1, 0);
    sw_req = 1'b0;
    chk("rearm_ack_count", 32'(ack_count), 32'd2);

    // POR loss in RUN: outputs drop SYNC_STAGES+1 edges after the drive.
    por_n = 1'b0;
    tick();
    chk("pordrop_e1_rst_n", 32'(rst_n), 32'h7);
    tick();
    chk("pordrop_e2_ready", 32'(ready), 32'h1);
    tick();
    chk("pordrop_e3_rst_n", 32'(rst_n), 32'h0);
    chk("pordrop_e3_ready", 32'(ready), 32'h0);
    check_seq("pordrop_hold", 100, 4, 1'b0, 0);

    // One-cycle POR glitch during filtering restarts the filter.
    por_n = 1'b1;
    check_seq("glitch_pre", 100, 10, 1'b0, 0);
    por_n = 1'b0;
    check_seq("glitch_low", 100, 1, 1'b0, 0);
    por_n = 1'b1;
    check_seq("glitch_post", 19, 36, 1'b0, 0);

    // RST_I during RELEASE, right after domain 1 released.
    por_n = 1'b0;
    repeat (4) tick();
    por_n = 1'b1;
    check_seq("midrel", 19, 27, 1'b0, 0);
    rst = 1'b1;
    tick();
    chk("midrel_abort_rst_n", 32'(rst_n), 32'h0);
    chk("midrel_abort_ready", 32'(ready), 32'h0);
    rst = 1'b0;
    check_seq("midrel_redo", 19, 36, 1'b0, 0);

    // RST_I during SW_HOLD: no ack, full filter sequence again.
    sw_req = 1'b1;
    check_seq("midsw", 100, 4, 1'b0, 0);
    rst = 1'b1;
    tick();
    chk("midsw_abort_rst_n", 32'(rst_n), 32'h0);
    rst = 1'b0; sw_req = 1'b0;
    check_seq("midsw_redo", 19, 36, 1'b0, 0);
    chk("midsw_ack_count", 32'(ack_count), 32'd2);

    // SW request and POR loss together: HOLD path wins, no ack.
    sw_req = 1'b1; por_n = 1'b0;
    check_seq("both", 100, 20, 1'b0, 0);
    sw_req = 1'b0; por_n = 1'b1;
    check_seq("both_redo", 19, 36, 1'b0, 0);
    chk("final_ack_count", 32'(ack_count), 32'd2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
